// File: rtl/morse_sequence_fifo.sv
// Multi-entry store for encoded Morse letter sequences: up to two writes per cycle, pop on Enter rise.
// Build option: define MORSE_FIFO_OVERWRITE_EN to discard oldest entries instead of newest on overflow.
module morse_sequence_fifo #(
  parameter  int SEQ_W = 10,
  parameter  int DEPTH = 8,
  localparam int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             wr_valid,
  input  logic [1:0]       wr_count,
  input  logic [SEQ_W-1:0] wr_seq0,
  input  logic [SEQ_W-1:0] wr_seq1,
  input  logic             Enter,
  output logic [SEQ_W-1:0] o_sequence,
  output logic             storageSent,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = LVL_W + 1;

  logic [SEQ_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [SEQ_W-1:0] o_sequence_q, o_sequence_d;
  logic             storage_sent_q, storage_sent_d;
  logic             overflow_q, overflow_d;
  logic             enter_q, enter_d;

  logic             pop_req, pop, over;
  logic [CNT_W-1:0] n_req, free_cnt, acc, skip, level_sum;
  logic             wr_en0, wr_en1;
  logic [PTR_W-1:0] wr_addr0, wr_addr1;

  always_comb begin
    pop_req = Enter & ~enter_q;
    pop     = pop_req & (level_q != '0);

    unique case (wr_count)
      2'd0:    n_req = '0;
      2'd1:    n_req = CNT_W'(1);
      default: n_req = CNT_W'(2);
    endcase
    if (!wr_valid) n_req = '0;

    // A slot vacated by this cycle's pop is already available to the write.
    free_cnt = CNT_W'(DEPTH) - CNT_W'(level_q) + CNT_W'(pop);
    over     = (n_req > free_cnt);
    acc      = n_req;
    skip     = '0;
    if (over) begin
`ifdef MORSE_FIFO_OVERWRITE_EN
      skip = n_req - free_cnt;
`else
      acc  = free_cnt;
`endif
    end

    level_sum = CNT_W'(level_q) + acc - CNT_W'(pop) - skip;

    wr_addr0 = wr_ptr_q;
    wr_addr1 = wr_ptr_q + PTR_W'(1);
    wr_en0   = ~Clear & (acc != '0);
    wr_en1   = ~Clear & (acc > CNT_W'(1));

    wr_ptr_d       = wr_ptr_q + PTR_W'(acc);
    rd_ptr_d       = rd_ptr_q + PTR_W'(pop) + PTR_W'(skip);
    level_d        = LVL_W'(level_sum);
    o_sequence_d   = pop ? mem_q[rd_ptr_q] : o_sequence_q;
    storage_sent_d = pop;
    overflow_d     = overflow_q | over;
    enter_d        = Enter;

    if (Clear) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      level_d        = '0;
      o_sequence_d   = '0;
      storage_sent_d = 1'b0;
      overflow_d     = 1'b0;
      enter_d        = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      o_sequence_q   <= '0;
      storage_sent_q <= 1'b0;
      overflow_q     <= 1'b0;
      enter_q        <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      o_sequence_q   <= o_sequence_d;
      storage_sent_q <= storage_sent_d;
      overflow_q     <= overflow_d;
      enter_q        <= enter_d;
    end
  end

  // Storage array is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en0) mem_q[wr_addr0] <= wr_seq0;
    if (wr_en1) mem_q[wr_addr1] <= wr_seq1;
  end

  assign o_sequence  = o_sequence_q;
  assign storageSent = storage_sent_q;
  assign level       = level_q;
  assign overflow    = overflow_q;
  assign full        = (level_q == LVL_W'(DEPTH));
  assign empty       = (level_q == '0);

endmodule

// File: tb/tb_morse_sequence_fifo.sv
// Directed bench for morse_sequence_fifo (DEPTH=8, SEQ_W=10).
module tb_morse_sequence_fifo;

  localparam int SEQ_W = 10;
  localparam int DEPTH = 8;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             Reset;
  logic             Clear;
  logic             wr_valid;
  logic [1:0]       wr_count;
  logic [SEQ_W-1:0] wr_seq0;
  logic [SEQ_W-1:0] wr_seq1;
  logic             Enter;
  logic [SEQ_W-1:0] o_sequence;
  logic             storageSent;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             overflow;

  int checks = 0;
  int errors = 0;

  morse_sequence_fifo #(.SEQ_W(SEQ_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .Reset(Reset), .Clear(Clear), .wr_valid(wr_valid),
    .wr_count(wr_count), .wr_seq0(wr_seq0), .wr_seq1(wr_seq1), .Enter(Enter),
    .o_sequence(o_sequence), .storageSent(storageSent), .full(full),
    .empty(empty), .level(level), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] cnt, input logic [SEQ_W-1:0] s0,
                          input logic [SEQ_W-1:0] s1);
    wr_valid = 1'b1; wr_count = cnt; wr_seq0 = s0; wr_seq1 = s1;
    tick();
    wr_valid = 1'b0; wr_count = 2'd0;
  endtask

  // Enter rise, check the popped value one clock later, then release Enter.
  task automatic pop_expect(input string name, input logic [SEQ_W-1:0] exp);
    Enter = 1'b1;
    tick();
    checks++;
    if (o_sequence !== exp || storageSent !== 1'b1) begin
      errors++;
      $display("FAIL %s o_sequence=%h storageSent=%b expected %h/1", name, o_sequence, storageSent, exp);
    end
    Enter = 1'b0;
    tick();
    checks++;
    if (storageSent !== 1'b0) begin
      errors++;
      $display("FAIL %s_pulse storageSent=%b expected 0", name, storageSent);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    checks++;
    if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
        o_sequence !== '0 || storageSent !== 1'b0) begin
      errors++;
      $display("FAIL reset level=%0d empty=%b full=%b ovf=%b o_seq=%h sent=%b expected 0/1/0/0/000/0",
               level, empty, full, overflow, o_sequence, storageSent);
    end
    #2 Reset = 1'b0;
    tick();
  endtask

  task automatic test_single_writes();
    do_write(2'd1, 10'h155, 10'h000);
    do_write(2'd1, 10'h2AA, 10'h000);
    do_write(2'd1, 10'h0FF, 10'h000);
    checks++;
    if (level !== LVL_W'(3) || empty !== 1'b0) begin
      errors++;
      $display("FAIL single_level level=%0d empty=%b expected 3/0", level, empty);
    end
    pop_expect("single_pop0", 10'h155);
    pop_expect("single_pop1", 10'h2AA);
    pop_expect("single_pop2", 10'h0FF);
    checks++;
    if (empty !== 1'b1 || level !== '0) begin
      errors++;
      $display("FAIL single_empty empty=%b level=%0d expected 1/0", empty, level);
    end
  endtask

  task automatic test_pair_write();
    do_write(2'd2, 10'h001, 10'h002);
    checks++;
    if (level !== LVL_W'(2)) begin
      errors++;
      $display("FAIL pair_level level=%0d expected 2", level);
    end
    pop_expect("pair_pop0", 10'h001);
    pop_expect("pair_pop1", 10'h002);
  endtask

  task automatic test_overflow();
    logic [SEQ_W-1:0] exp;
    for (int k = 0; k < 4; k++)
      do_write(2'd2, SEQ_W'(10'h010 + 2*k), SEQ_W'(10'h011 + 2*k));
    checks++;
    if (full !== 1'b1 || overflow !== 1'b0 || level !== LVL_W'(8)) begin
      errors++;
      $display("FAIL ovf_fill full=%b ovf=%b level=%0d expected 1/0/8", full, overflow, level);
    end
    do_write(2'd3, 10'h3A0, 10'h3A1);
    checks++;
    if (full !== 1'b1 || overflow !== 1'b1 || level !== LVL_W'(8)) begin
      errors++;
      $display("FAIL ovf_after full=%b ovf=%b level=%0d expected 1/1/8", full, overflow, level);
    end
    for (int i = 0; i < 8; i++) begin
`ifdef MORSE_FIFO_OVERWRITE_EN
      exp = (i < 6) ? SEQ_W'(10'h012 + i) : SEQ_W'(10'h3A0 + (i - 6));
`else
      exp = SEQ_W'(10'h010 + i);
`endif
      pop_expect("ovf_drain", exp);
    end
    checks++;
    if (empty !== 1'b1 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky empty=%b ovf=%b expected 1/1", empty, overflow);
    end
    Clear = 1'b1;
    tick();
    Clear = 1'b0;
    checks++;
    if (overflow !== 1'b0 || o_sequence !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL ovf_clear ovf=%b o_seq=%h empty=%b expected 0/000/1", overflow, o_sequence, empty);
    end
  endtask

  task automatic test_full_pop_write();
    for (int k = 0; k < 8; k++)
      do_write(2'd1, SEQ_W'(10'h020 + k), 10'h000);
    Enter = 1'b1;
    wr_valid = 1'b1; wr_count = 2'd1; wr_seq0 = 10'h3FF;
    tick();
    wr_valid = 1'b0; wr_count = 2'd0;
    checks++;
    if (o_sequence !== 10'h020 || storageSent !== 1'b1 || level !== LVL_W'(8) ||
        overflow !== 1'b0 || full !== 1'b1) begin
      errors++;
      $display("FAIL fullpw o_seq=%h sent=%b level=%0d ovf=%b full=%b expected 020/1/8/0/1",
               o_sequence, storageSent, level, overflow, full);
    end
    Enter = 1'b0;
    tick();
    for (int i = 1; i < 8; i++)
      pop_expect("fullpw_drain", SEQ_W'(10'h020 + i));
    pop_expect("fullpw_new", 10'h3FF);
  endtask

  task automatic test_enter_hold();
    int pulses;
    do_write(2'd2, 10'h005, 10'h006);
    pulses = 0;
    Enter = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (storageSent === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || level !== LVL_W'(1) || o_sequence !== 10'h005) begin
      errors++;
      $display("FAIL hold pulses=%0d level=%0d o_seq=%h expected 1/1/005", pulses, level, o_sequence);
    end
    Enter = 1'b0;
    tick();
    pop_expect("hold_next", 10'h006);
    Enter = 1'b1;
    tick();
    checks++;
    if (storageSent !== 1'b0 || o_sequence !== 10'h006 || level !== '0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL empty_pop sent=%b o_seq=%h level=%0d ovf=%b expected 0/006/0/0",
               storageSent, o_sequence, level, overflow);
    end
    Enter = 1'b0;
    tick();
  endtask

  task automatic test_clear_reset();
    do_write(2'd2, 10'h0AA, 10'h0BB);
    Clear = 1'b1; Enter = 1'b1;
    wr_valid = 1'b1; wr_count = 2'd1; wr_seq0 = 10'h0CC;
    tick();
    Clear = 1'b0; Enter = 1'b0; wr_valid = 1'b0; wr_count = 2'd0;
    checks++;
    if (level !== '0 || empty !== 1'b1 || storageSent !== 1'b0 || o_sequence !== '0) begin
      errors++;
      $display("FAIL clear_prio level=%0d empty=%b sent=%b o_seq=%h expected 0/1/0/000",
               level, empty, storageSent, o_sequence);
    end
    tick();
    do_write(2'd2, 10'h111, 10'h122);
    pop_expect("pre_reset_pop", 10'h111);
    for (int k = 0; k < 4; k++)
      do_write(2'd2, SEQ_W'(10'h130 + k), SEQ_W'(10'h140 + k));
    checks++;
    if (overflow !== 1'b1 || level !== LVL_W'(8)) begin
      errors++;
      $display("FAIL pre_reset ovf=%b level=%0d expected 1/8", overflow, level);
    end
    wr_valid = 1'b1; wr_count = 2'd2; Enter = 1'b1;
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (level !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
        o_sequence !== '0 || storageSent !== 1'b0) begin
      errors++;
      $display("FAIL async_reset level=%0d empty=%b full=%b ovf=%b o_seq=%h sent=%b expected 0/1/0/0/000/0",
               level, empty, full, overflow, o_sequence, storageSent);
    end
    tick();
    wr_valid = 1'b0; wr_count = 2'd0; Enter = 1'b0;
    #2 Reset = 1'b0;
    tick();
    checks++;
    if (level !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL post_reset level=%0d empty=%b expected 0/1", level, empty);
    end
    do_write(2'd1, 10'h01A, 10'h000);
    pop_expect("post_reset_pop", 10'h01A);
  endtask

  initial begin
    Reset = 1'b1; Clear = 1'b0; wr_valid = 1'b0; wr_count = 2'd0;
    wr_seq0 = '0; wr_seq1 = '0; Enter = 1'b0;
    test_reset();
    test_single_writes();
    test_pair_write();
    test_overflow();
    test_full_pop_write();
    test_enter_hold();
    test_clear_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
